// File: rtl/aes_ks_inv.sv
// Inverse AES key schedule: walks from the final round key back to the cipher key, one round per en_i.
// Optional AES-256 support is compiled in with KS_INV_AES256_EN.

module aes_sbox #(
    parameter bit DEC = 1'b0
) (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] x2, x4, x8, x16, x32, x64, x128;
        x2   = gmul(x, x);
        x4   = gmul(x2, x2);
        x8   = gmul(x4, x4);
        x16  = gmul(x8, x8);
        x32  = gmul(x16, x16);
        x64  = gmul(x32, x32);
        x128 = gmul(x64, x64);
        return gmul(gmul(gmul(x2, x4), gmul(x8, x16)), gmul(gmul(x32, x64), x128));
    endfunction

    logic [7:0] aff_in;
    logic [7:0] inv;

    always_comb begin
        aff_in = in_i;
        if (DEC)
            aff_in = {in_i[6:0], in_i[7]} ^ {in_i[4:0], in_i[7:5]} ^ {in_i[1:0], in_i[7:2]} ^ 8'h05;
        inv = ginv(aff_in);
        if (DEC)
            out_o = inv;
        else
            out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_ks_inv (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [1:0]   size_i,
    input  logic [255:0] key_i,
    output logic [127:0] ks_o,
    output logic [3:0]   rnd_o,
    output logic         done_o
);
`ifdef KS_INV_AES256_EN
    localparam int SW = 256;
`else
    localparam int SW = 128;
`endif

    logic [SW-1:0] state_q, state_d;
    logic [127:0]  ks_q, ks_d;
    logic [3:0]    rnd_q, rnd_d;
    logic          done_q, done_d;
    logic [7:0]    rcon_q, rcon_d;

    logic [31:0]   l0, l1, l2, l3, n0, n1, n2, n3;
    logic [31:0]   sb_src, sb_in, sb_out, t_w;
    logic [127:0]  n_key;
    logic [7:0]    rcon_prev;
    logic          use_rot;

    assign l0 = state_q[127:96];
    assign l1 = state_q[95:64];
    assign l2 = state_q[63:32];
    assign l3 = state_q[31:0];
    assign n3 = l3 ^ l2;
    assign n2 = l2 ^ l1;
    assign n1 = l1 ^ l0;

`ifdef KS_INV_AES256_EN
    logic size_q, size_d;
    // AES-256 alternates RotWord+Rcon rounds (even rnd) with SubWord-only rounds (odd rnd).
    assign use_rot = !size_q || !rnd_q[0];
    assign sb_src  = size_q ? state_q[159:128] : n3;
`else
    logic unused_ok;
    assign unused_ok = ^{size_i, key_i[255:128]};
    assign use_rot   = 1'b1;
    assign sb_src    = n3;
`endif

    assign sb_in = use_rot ? {sb_src[23:0], sb_src[31:24]} : sb_src;

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox #(.DEC(1'b0)) u_sbox (
            .in_i  (sb_in[8*i +: 8]),
            .out_o (sb_out[8*i +: 8])
        );
    end

    assign t_w       = sb_out ^ (use_rot ? {rcon_q, 24'h0} : 32'h0);
    assign n0        = l0 ^ t_w;
    assign n_key     = {n0, n1, n2, n3};
    assign rcon_prev = {1'b0, rcon_q[7:1]} ^ (rcon_q[0] ? 8'h8d : 8'h00);

    always_comb begin
        state_d = state_q;
        ks_d    = ks_q;
        rnd_d   = rnd_q;
        done_d  = done_q;
        rcon_d  = rcon_q;
`ifdef KS_INV_AES256_EN
        size_d  = size_q;
`endif
        if (load_i) begin
            ks_d   = key_i[127:0];
            done_d = 1'b0;
`ifdef KS_INV_AES256_EN
            size_d  = (size_i == 2'd2);
            state_d = key_i;
            rnd_d   = size_d ? 4'd14 : 4'd10;
            rcon_d  = size_d ? 8'h40 : 8'h36;
`else
            state_d = key_i[127:0];
            rnd_d   = 4'd10;
            rcon_d  = 8'h36;
`endif
        end else if (en_i && !done_q && rnd_q != 4'd0) begin
            // rnd_q==0 with done_q low only happens before the first load: nothing to walk.
            rnd_d  = rnd_q - 4'd1;
            done_d = (rnd_q == 4'd1);
            if (use_rot) rcon_d = rcon_prev;
`ifdef KS_INV_AES256_EN
            if (size_q) begin
                ks_d    = state_q[255:128];
                state_d = {n_key, state_q[255:128]};
            end else begin
                ks_d    = n_key;
                state_d = {state_q[255:128], n_key};
            end
`else
            ks_d    = n_key;
            state_d = n_key;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            ks_q    <= '0;
            rnd_q   <= '0;
            done_q  <= 1'b0;
            rcon_q  <= '0;
`ifdef KS_INV_AES256_EN
            size_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ks_q    <= ks_d;
            rnd_q   <= rnd_d;
            done_q  <= done_d;
            rcon_q  <= rcon_d;
`ifdef KS_INV_AES256_EN
            size_q  <= size_d;
`endif
        end
    end

    assign ks_o   = ks_q;
    assign rnd_o  = rnd_q;
    assign done_o = done_q;
endmodule

// File: tb/tb_aes_ks_inv.sv
// Directed bench for aes_ks_inv: FIPS-197 vectors plus round trips against a table-driven forward schedule.
module tb_aes_ks_inv;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load_i = 1'b0;
    logic         en_i = 1'b0;
    logic [1:0]   size_i = 2'd0;
    logic [255:0] key_i = '0;
    logic [127:0] ks_o;
    logic [3:0]   rnd_o;
    logic         done_o;

    int tests = 0;
    int fails = 0;
    logic [127:0] rk [0:14];

    aes_ks_inv dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load_i),
        .en_i   (en_i),
        .size_i (size_i),
        .key_i  (key_i),
        .ks_o   (ks_o),
        .rnd_o  (rnd_o),
        .done_o (done_o)
    );

    always #5 clk = ~clk;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [2047:0] t;
        t = SBOX;
        return t[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    task automatic expand128(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic expand256(input logic [255:0] key);
        logic [31:0] w [0:59];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = xt(rc);
            end else if (i % 8 == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-8] ^ tmp;
        end
        for (int r = 0; r <= 14; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic do_load(input logic [255:0] k, input logic [1:0] s);
        load_i = 1'b1; key_i = k; size_i = s;
        @(posedge clk); #1;
        load_i = 1'b0;
    endtask

    task automatic do_step();
        en_i = 1'b1;
        @(posedge clk); #1;
        en_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if ({ks_o, rnd_o, done_o} !== {128'h0, 4'd0, 1'b0}) begin
            fails++; $display("FAIL reset: ks=%h rnd=%0d done=%b want 0/0/0", ks_o, rnd_o, done_o);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (3) do_step();
        tests++;
        if ({ks_o, rnd_o, done_o} !== {128'h0, 4'd0, 1'b0}) begin
            fails++; $display("FAIL en_before_load: ks=%h rnd=%0d done=%b want 0/0/0", ks_o, rnd_o, done_o);
        end
    endtask

    task automatic test_aes128_vector();
        do_load({128'hdeadbeef_01234567_89abcdef_55aa55aa, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6}, 2'd0);
        tests++;
        if ({ks_o, rnd_o, done_o} !== {128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6, 4'd10, 1'b0}) begin
            fails++; $display("FAIL load128: ks=%h rnd=%0d done=%b want rk10/10/0", ks_o, rnd_o, done_o);
        end
        do_step();
        tests++;
        if ({ks_o, rnd_o} !== {128'hac7766f3_19fadc21_28d12941_575c006e, 4'd9}) begin
            fails++; $display("FAIL step128_rk9: ks=%h rnd=%0d want ac7766f3...006e/9", ks_o, rnd_o);
        end
        repeat (8) do_step();
        tests++;
        if ({rnd_o, done_o} !== {4'd1, 1'b0}) begin
            fails++; $display("FAIL step128_rk1: rnd=%0d done=%b want 1/0", rnd_o, done_o);
        end
        do_step();
        tests++;
        if ({ks_o, rnd_o, done_o} !== {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 4'd0, 1'b1}) begin
            fails++; $display("FAIL step128_rk0: ks=%h rnd=%0d done=%b want 2b7e...4f3c/0/1", ks_o, rnd_o, done_o);
        end
        repeat (2) do_step();
        tests++;
        if ({ks_o, rnd_o, done_o} !== {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 4'd0, 1'b1}) begin
            fails++; $display("FAIL en_after_done: ks=%h rnd=%0d done=%b want unchanged", ks_o, rnd_o, done_o);
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] keys [0:2];
        keys[0] = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
        keys[1] = {$urandom, $urandom, $urandom, $urandom};
        keys[2] = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < 3; k++) begin
            expand128(keys[k]);
            do_load({128'h0, rk[10]}, 2'd0);
            for (int r = 9; r >= 0; r--) begin
                do_step();
                tests++;
                if ({ks_o, rnd_o} !== {rk[r], 4'(r)}) begin
                    fails++; $display("FAIL round_trip k%0d r%0d: ks=%h rnd=%0d want %h/%0d", k, r, ks_o, rnd_o, rk[r], r);
                end
            end
            tests++;
            if (done_o !== 1'b1) begin
                fails++; $display("FAIL round_trip_done k%0d: done=%b want 1", k, done_o);
            end
        end
    endtask

    task automatic test_load_priority();
        logic [127:0] kb;
        logic [127:0] rk9_b;
        kb = {$urandom, $urandom, $urandom, $urandom};
        expand128(kb);
        rk9_b = rk[9];
        do_load({128'h0, kb ^ 128'h1}, 2'd0);
        repeat (5) do_step();
        tests++;
        if (rnd_o !== 4'd5) begin
            fails++; $display("FAIL prio_setup: rnd=%0d want 5", rnd_o);
        end
        en_i = 1'b1;
        do_load({128'h0, rk[10]}, 2'd0);
        en_i = 1'b0;
        tests++;
        if ({ks_o, rnd_o, done_o} !== {rk[10], 4'd10, 1'b0}) begin
            fails++; $display("FAIL load_wins: ks=%h rnd=%0d done=%b want %h/10/0", ks_o, rnd_o, done_o, rk[10]);
        end
        do_step();
        tests++;
        if (ks_o !== rk9_b) begin
            fails++; $display("FAIL reload_step: ks=%h want %h", ks_o, rk9_b);
        end
    endtask

    task automatic test_reset_mid_walk();
        expand128(128'h000102030405060708090a0b0c0d0e0f);
        do_load({128'h0, rk[10]}, 2'd0);
        repeat (6) do_step();
        tests++;
        if ({ks_o, rnd_o} !== {rk[4], 4'd4}) begin
            fails++; $display("FAIL mid_walk: ks=%h rnd=%0d want %h/4", ks_o, rnd_o, rk[4]);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({ks_o, rnd_o, done_o} !== {128'h0, 4'd0, 1'b0}) begin
            fails++; $display("FAIL async_reset: ks=%h rnd=%0d done=%b want 0/0/0", ks_o, rnd_o, done_o);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (2) do_step();
        tests++;
        if ({rnd_o, done_o} !== {4'd0, 1'b0}) begin
            fails++; $display("FAIL post_reset_en: rnd=%0d done=%b want 0/0", rnd_o, done_o);
        end
        do_load({128'h0, rk[10]}, 2'd0);
        do_step();
        tests++;
        if ({ks_o, rnd_o} !== {rk[9], 4'd9}) begin
            fails++; $display("FAIL restart: ks=%h rnd=%0d want %h/9", ks_o, rnd_o, rk[9]);
        end
    endtask

    task automatic test_size_alias();
        logic [1:0] sizes [0:2];
        int n;
        sizes[0] = 2'd1; sizes[1] = 2'd3; sizes[2] = 2'd2;
`ifdef KS_INV_AES256_EN
        n = 2;
`else
        n = 3;
`endif
        for (int i = 0; i < n; i++) begin
            expand128({$urandom, $urandom, $urandom, $urandom});
            do_load({$urandom, $urandom, $urandom, $urandom, rk[10]}, sizes[i]);
            tests++;
            if (rnd_o !== 4'd10) begin
                fails++; $display("FAIL size_alias s%0d: rnd=%0d want 10", sizes[i], rnd_o);
            end
            do_step();
            tests++;
            if (ks_o !== rk[9]) begin
                fails++; $display("FAIL size_alias_step s%0d: ks=%h want %h", sizes[i], ks_o, rk[9]);
            end
        end
    endtask

`ifdef KS_INV_AES256_EN
    task automatic test_aes256();
        expand256(256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4);
        do_load({rk[13], rk[14]}, 2'd2);
        tests++;
        if ({ks_o, rnd_o, done_o} !== {128'hfe4890d1_e6188d0b_046df344_706c631e, 4'd14, 1'b0}) begin
            fails++; $display("FAIL load256: ks=%h rnd=%0d done=%b want fe4890d1...631e/14/0", ks_o, rnd_o, done_o);
        end
        for (int r = 13; r >= 0; r--) begin
            do_step();
            tests++;
            if ({ks_o, rnd_o} !== {rk[r], 4'(r)}) begin
                fails++; $display("FAIL step256 r%0d: ks=%h rnd=%0d want %h/%0d", r, ks_o, rnd_o, rk[r], r);
            end
            if (r == 1) begin
                tests++;
                if (ks_o !== 128'h1f352c07_3b6108d7_2d9810a3_0914dff4) begin
                    fails++; $display("FAIL aes256_rk1: ks=%h want 1f352c07...dff4", ks_o);
                end
            end
        end
        tests++;
        if ({ks_o, done_o} !== {128'h603deb10_15ca71be_2b73aef0_857d7781, 1'b1}) begin
            fails++; $display("FAIL aes256_rk0: ks=%h done=%b want 603deb10...7781/1", ks_o, done_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_aes128_vector();
        test_round_trip();
        test_load_priority();
        test_reset_mid_walk();
        test_size_alias();
`ifdef KS_INV_AES256_EN
        test_aes256();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
